keyed_lfsr_load_gen: RTL

Parametrised successor of the fixed 128-bit-key / 64-bit-load LFSR payload generator.
- Generalises key width, load width, LFSR width and taps.
- Adds a seed-load handshake, enable/warm-up sequencing, four combine modes and a load_valid qualifier.
- Sits beside a datapath host: consumes the host's key stream and returns a load word that the host folds into its result path.

---
 rtl/keyed_lfsr_load_gen.sv | 88 ++++++++
 1 files changed

// File: rtl/keyed_lfsr_load_gen.sv
// keyed_lfsr_load_gen: keyed LFSR payload generator with seed handshake, warm-up sequencing and four combine modes.
module keyed_lfsr_load_gen #(
  parameter int KEY_WIDTH = 128,
  parameter int LOAD_WIDTH = 64,
  parameter int LFSR_WIDTH = 20,
  parameter logic [LFSR_WIDTH-1:0] TAP_MASK = 20'h08881,
  parameter logic [LFSR_WIDTH-1:0] INIT_VALUE = 20'h99999,
  parameter logic [LOAD_WIDTH-1:0] LOAD_XOR_MASK = 64'h8FADC1A6B5E37921,
  parameter int WARMUP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  seed_valid,
  input  logic [LFSR_WIDTH-1:0] seed,
  output logic                  seed_ready,
  input  logic [KEY_WIDTH-1:0]  key,
  output logic [LOAD_WIDTH-1:0] load,
  output logic                  load_valid,
  output logic [LFSR_WIDTH-1:0] lfsr_state
);
  localparam int CW = WARMUP_CYCLES > 0 ? $clog2(WARMUP_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;
  state_t state, state_nx;
  logic [LFSR_WIDTH-1:0] lfsr, lfsr_nx, lfsr_cand, lfsr_step;
  logic [CW-1:0] cnt, cnt_nx;
  logic [LOAD_WIDTH-1:0] load_nx, load_comb;
  logic load_valid_nx;
  assign lfsr_step = {^(lfsr & TAP_MASK), lfsr[LFSR_WIDTH-1:1]};
  assign seed_ready = state == IDLE;
  assign lfsr_state = lfsr;
  always_comb begin
    load_comb = '0;
    for (int i = 0; i < LOAD_WIDTH; i++) begin
      load_comb[i] = mode == 2'd0 ? key[i % KEY_WIDTH] ^ lfsr[i % LFSR_WIDTH] ^ LOAD_XOR_MASK[i] :
                     mode == 2'd1 ? key[i % KEY_WIDTH] ^ LOAD_XOR_MASK[i] :
                     mode == 2'd2 ? key[i % KEY_WIDTH] ^ lfsr[(i + 1) % LFSR_WIDTH] ^ LOAD_XOR_MASK[i] :
                                    load[i] ^ key[i % KEY_WIDTH] ^ lfsr[i % LFSR_WIDTH];
    end
  end
  // Dropping en in WARMUP or RUN freezes the LFSR and returns to IDLE.
  always_comb begin
    state_nx = state;
    lfsr_cand = lfsr;
    cnt_nx = cnt;
    load_nx = load;
    load_valid_nx = 1'b0;
    if (state == IDLE) begin
      if (seed_valid) lfsr_cand = seed;
      else if (en) begin
        state_nx = WARMUP_CYCLES == 0 ? RUN : WARMUP;
        cnt_nx = '0;
      end
    end else if (!en) begin
      state_nx = IDLE;
      cnt_nx = '0;
    end else begin
      lfsr_cand = lfsr_step;
      if (state == WARMUP) begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(WARMUP_CYCLES - 1)) begin
          state_nx = RUN;
          cnt_nx = '0;
        end
      end else begin
        load_nx = load_comb;
        load_valid_nx = 1'b1;
      end
    end
    lfsr_nx = lfsr_cand == '0 ? INIT_VALUE : lfsr_cand;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lfsr <= INIT_VALUE;
      cnt <= '0;
      load <= '0;
      load_valid <= 1'b0;
    end else begin
      state <= state_nx;
      lfsr <= lfsr_nx;
      cnt <= cnt_nx;
      load <= load_nx;
      load_valid <= load_valid_nx;
    end
  end
endmodule
